// File: rtl/m6809_sys_pkg.sv
// m6809_sys_pkg: shared arbiter state encoding and 6809 BA/BS status decode
package m6809_sys_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GUARD   = 3'd4
    } state_t;
    localparam logic [1:0] BABS_RUN   = 2'b00;
    localparam logic [1:0] BABS_IACK  = 2'b01;
    localparam logic [1:0] BABS_SYNC  = 2'b10;
    localparam logic [1:0] BABS_GRANT = 2'b11;
endpackage

// File: rtl/m6809_rr_pick.sv
// m6809_rr_pick: first set request at or after the pointer, wrapping modulo N
module m6809_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);
    // descending scan so the nearest set bit from the pointer is written last
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_valid = 1'b1;
                o_idx   = IW'((int'(i_ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/m6809_dma_arbiter.sv
// m6809_dma_arbiter: round-robin DMA bus arbiter with burst limit for the 6809 bus
module m6809_dma_arbiter
    import m6809_sys_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 14,
    parameter int GUARD     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_ba,
    input  logic                    i_bs,
    output logic                    o_breq_b,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_gnt_id,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic                    o_abort
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
    localparam logic [1:0] GLIM = 2'(GUARD);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_gcnt;
    logic          w_bus_ok;
    logic          w_valid;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_nxt_ptr;

    assign w_bus_ok  = {i_ba, i_bs} == BABS_GRANT;
    assign w_nxt_ptr = (o_gnt_id == IW'(NREQ - 1)) ? '0 : o_gnt_id + 1'b1;

    m6809_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // arbiter FSM; every output is a register so the CPU sees clean levels
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            o_breq_b  <= 1'b1;
            o_gnt     <= '0;
            o_gnt_id  <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
            o_abort   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            o_abort   <= 1'b0;
            case (r_state)
                ST_IDLE: if (|i_req) begin
                    r_state  <= ST_REQUEST;
                    o_breq_b <= 1'b0;
                    o_busy   <= 1'b1;
                end
                ST_REQUEST: if (w_bus_ok && w_valid) begin
                    r_state  <= ST_GRANT;
                    o_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
                    o_gnt_id <= w_idx;
                    r_cnt    <= CW'(1);
                end else if (!(|i_req)) begin
                    r_state  <= ST_RELEASE;
                    o_breq_b <= 1'b1;
                end
                ST_GRANT: begin
                    r_cnt <= (r_cnt == CMAX) ? r_cnt : r_cnt + 1'b1;
                    // abort wins over a simultaneous burst-limit cut
                    if (!w_bus_ok || !i_req[o_gnt_id] || r_cnt == CMAX) begin
                        r_state   <= ST_RELEASE;
                        o_gnt     <= '0;
                        o_breq_b  <= 1'b1;
                        r_ptr     <= w_nxt_ptr;
                        o_abort   <= !w_bus_ok;
                        o_timeout <= w_bus_ok && i_req[o_gnt_id] && r_cnt == CMAX;
                    end
                end
                ST_RELEASE: if (!i_ba) begin
                    r_state <= (GUARD > 0) ? ST_GUARD : ST_IDLE;
                    o_busy  <= GUARD > 0;
                    r_gcnt  <= 2'd1;
                end
                ST_GUARD: if (r_gcnt == GLIM) begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end else begin
                    r_gcnt <= r_gcnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m6809_dma_arbiter.sv
// tb_m6809_dma_arbiter: directed self-checking bench for the DMA bus arbiter
module tb_m6809_dma_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       ba  = 1'b0;
    logic       bs  = 1'b0;
    logic       breq_b;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic       abort_p;
    int         n_checks = 0;
    int         n_errors = 0;

    m6809_dma_arbiter #(.NREQ(4), .MAX_BURST(14), .GUARD(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_ba      (ba),
        .i_bs      (bs),
        .o_breq_b  (breq_b),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_busy    (busy),
        .o_timeout (timeout),
        .o_abort   (abort_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full grant from IDLE: latency lat cycles to BA/BS, hold cycles granted, then release
    task automatic serve(input int id, input int lat, input int hold);
        tick();
        check("req_breq_low", 32'(breq_b), 0);
        check("req_no_gnt", 32'(gnt), 0);
        repeat (lat - 1) tick();
        ba = 1'b1;
        bs = 1'b1;
        tick();
        check("gnt_onehot", 32'(gnt), 32'(1) << id);
        check("gnt_id", 32'(gnt_id), 32'(id));
        repeat (hold - 1) tick();
        check("gnt_held", 32'(gnt), 32'(1) << id);
        req[id] = 1'b0;
        tick();
        check("rel_gnt", 32'(gnt), 0);
        check("rel_breq", 32'(breq_b), 1);
        check("rel_timeout", 32'(timeout), 0);
        ba = 1'b0;
        bs = 1'b0;
        tick();
        check("guard_busy", 32'(busy), 1);
        tick();
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ba  = 1'b0;
        bs  = 1'b0;
        repeat (2) tick();
        check("rst_breq", 32'(breq_b), 1);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_id", 32'(gnt_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({timeout, abort_p}), 0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        // single request, BA/BS answer late
        req = 4'b0001;
        serve(0, 3, 5);
        // round robin from pointer 0, requesters re-raise after each grant
        do_reset();
        req = 4'b1011;
        serve(0, 1, 3);
        req = 4'b1011;
        serve(1, 1, 3);
        req = 4'b1011;
        serve(3, 1, 3);
        req = 4'b1011;
        serve(0, 1, 3);
        // burst limit on a held request
        req = 4'b0100;
        tick();
        ba = 1'b1;
        bs = 1'b1;
        tick();
        check("burst_gnt", 32'(gnt), 32'b0100);
        repeat (13) tick();
        check("burst_last", 32'(gnt), 32'b0100);
        check("burst_no_to", 32'(timeout), 0);
        tick();
        check("burst_cut", 32'(gnt), 0);
        check("burst_to", 32'(timeout), 1);
        check("burst_breq", 32'(breq_b), 1);
        tick();
        check("to_pulse_end", 32'(timeout), 0);
        check("rel_holds", 32'(gnt), 0);
        ba = 1'b0;
        bs = 1'b0;
        tick();
        check("burst_guard", 32'(busy), 1);
        tick();
        check("burst_idle", 32'(busy), 0);
        tick();
        check("regrant_req", 32'(breq_b), 0);
        ba = 1'b1;
        bs = 1'b1;
        tick();
        check("regrant_gnt", 32'(gnt), 32'b0100);
        // CPU reclaims the bus on the same edge the burst limit would fire
        repeat (13) tick();
        ba = 1'b0;
        bs = 1'b0;
        tick();
        check("abort_gnt", 32'(gnt), 0);
        check("abort_breq", 32'(breq_b), 1);
        check("abort_pulse", 32'(abort_p), 1);
        check("abort_no_to", 32'(timeout), 0);
        tick();
        check("abort_end", 32'(abort_p), 0);
        req = '0;
        tick();
        check("abort_idle", 32'(busy), 0);
        // withdraw before the CPU frees the bus
        req = 4'b0010;
        tick();
        check("wd_breq", 32'(breq_b), 0);
        tick();
        req = '0;
        tick();
        check("wd_breq_hi", 32'(breq_b), 1);
        check("wd_gnt", 32'(gnt), 0);
        tick();
        check("wd_gnt2", 32'(gnt), 0);
        tick();
        check("wd_idle", 32'(busy), 0);
        // asynchronous reset in the middle of a grant
        req = 4'b0010;
        tick();
        ba = 1'b1;
        bs = 1'b1;
        tick();
        check("ar_gnt", 32'(gnt), 32'b0010);
        #2 rst = 1'b1;
        #1;
        check("ar_breq", 32'(breq_b), 1);
        check("ar_gnt0", 32'(gnt), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_id", 32'(gnt_id), 0);
        #1 rst = 1'b0;
        req = 4'b1001;
        tick();
        check("ar_req", 32'(breq_b), 0);
        tick();
        check("ar_ptr0_gnt", 32'(gnt), 32'b0001);
        check("ar_ptr0_id", 32'(gnt_id), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
